muldiv_unit: RTL and testbench

- Iterative 16-bit multiply/divide unit that owns the architectural Hi and Lo registers.
- Sits beside the EX stage: the EX stage issues MULT/MULTU/DIV/DIVU and MTHI/MTLO, and reads Hi/Lo for MFHI/MFLO.
- Multiply uses radix-2 shift-add; divide uses restoring division. Each takes 16 iteration cycles plus one sign-fix cycle.
- busy drives the hazard unit, which freezes PC, IF/ID and ID/EX while an operation is in flight.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_signfix.sv | 12 +
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   localparam int unsigned MD_WIDTH  = 16;
   localparam logic [3:0]  ITER_LAST = 4'd15;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_op_e;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } md_state_e;

   function automatic logic md_is_signed(input md_op_e op);
      return !op[0];
   endfunction

   function automatic logic md_is_div(input md_op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: magnitude at capture, sign restore at FIX.
module muldiv_signfix #(
   parameter int unsigned W = 16
) (
   input  logic [W-1:0] val,
   input  logic         neg,
   output logic [W-1:0] mag_c
);

   always_comb mag_c = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the Hi and Lo registers.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned ITER  = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             sign_a_q, sign_a_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] mag_b_q, mag_b_d;
   logic [WIDTH-1:0] raw_a_q, raw_a_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;

   logic               sa_c, sb_c;
   logic [WIDTH-1:0]   mag_a_c, mag_b_c;
   logic [WIDTH:0]     mul_sum_c;
   logic [WIDTH:0]     div_shift_c;
   logic [WIDTH+1:0]   div_diff_c;
   logic               div_borrow_c;
   logic [2*WIDTH-1:0] prod_fix_c;
   logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;

   assign sa_c = md_is_signed(md_op_e'(op)) & operand_a[WIDTH-1];
   assign sb_c = md_is_signed(md_op_e'(op)) & operand_b[WIDTH-1];

   muldiv_signfix #(.W(WIDTH)) u_abs_a (.val(operand_a), .neg(sa_c), .mag_c(mag_a_c));
   muldiv_signfix #(.W(WIDTH)) u_abs_b (.val(operand_b), .neg(sb_c), .mag_c(mag_b_c));

   muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (
      .val({acc_hi_q, acc_lo_q}), .neg(neg_q), .mag_c(prod_fix_c));
   muldiv_signfix #(.W(WIDTH)) u_fix_quo (.val(acc_lo_q), .neg(neg_q), .mag_c(quo_fix_c));
   muldiv_signfix #(.W(WIDTH)) u_fix_rem (.val(acc_hi_q), .neg(sign_a_q), .mag_c(rem_fix_c));

   // One iteration of each algorithm; the remainder always fits WIDTH bits after a step.
   assign mul_sum_c    = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
   assign div_shift_c  = {acc_hi_q, acc_lo_q[WIDTH-1]};
   assign div_diff_c   = {1'b0, div_shift_c} - {2'b00, mag_b_q};
   assign div_borrow_c = div_diff_c[WIDTH+1];

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      sign_a_d = sign_a_q;
      neg_d    = neg_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      mag_b_d  = mag_b_q;
      raw_a_d  = raw_a_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      dbz_d    = dbz_q;

      unique case (state_q)
         MD_IDLE: begin
            if (hi_we) hi_d = wr_data;
            if (lo_we) lo_d = wr_data;
            if (start) begin
               op_d     = md_op_e'(op);
               sign_a_d = sa_c;
               neg_d    = sa_c ^ sb_c;
               acc_hi_d = '0;
               acc_lo_d = mag_a_c;
               mag_b_d  = mag_b_c;
               raw_a_d  = operand_a;
               cnt_d    = '0;
               dbz_d    = 1'b0;
               busy_d   = 1'b1;
               state_d  = MD_CALC;
            end
         end
         MD_CALC: begin
            cnt_d = cnt_q + 4'd1;
            if (md_is_div(op_q)) begin
               acc_hi_d = div_borrow_c ? div_shift_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], ~div_borrow_c};
            end else begin
               acc_hi_d = mul_sum_c[WIDTH:1];
               acc_lo_d = {mul_sum_c[0], acc_lo_q[WIDTH-1:1]};
            end
            if (cnt_q == CNT_LAST) state_d = MD_FIX;
         end
         MD_FIX: begin
            state_d = MD_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            if (md_is_div(op_q)) begin
               if (mag_b_q == '0) begin
                  hi_d  = raw_a_q;
                  lo_d  = '1;
                  dbz_d = 1'b1;
               end else begin
                  hi_d = rem_fix_c;
                  lo_d = quo_fix_c;
               end
            end else begin
               hi_d = prod_fix_c[2*WIDTH-1:WIDTH];
               lo_d = prod_fix_c[WIDTH-1:0];
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state_q  <= MD_IDLE;
         op_q     <= MD_MULT;
         cnt_q    <= '0;
         sign_a_q <= 1'b0;
         neg_q    <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         mag_b_q  <= '0;
         raw_a_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         sign_a_q <= sign_a_d;
         neg_q    <= neg_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         mag_b_q  <= mag_b_d;
         raw_a_q  <= raw_a_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign Hi          = hi_q;
   assign Lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed scoreboard bench for muldiv_unit: latency, results, flags and Hi/Lo writes.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rest;
   logic        start;
   logic [1:0]  op;
   logic [15:0] operand_a, operand_b;
   logic        hi_we, lo_we;
   logic [15:0] wr_data;
   logic        busy, done, div_by_zero;
   logic [15:0] Hi, Lo;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   muldiv_unit dut (
      .clk(clk), .rest(rest), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data),
      .busy(busy), .done(done), .div_by_zero(div_by_zero),
      .Hi(Hi), .Lo(Lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Caller sits just after a negedge; returns just after the negedge following the start edge.
   task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] eh, input logic [15:0] el, input logic ed,
                        input bit push);
      exp_t e;
      start = 1'b1; op = o; operand_a = a; operand_b = b;
      if (push) begin
         e.hi = eh; e.lo = el; e.dbz = ed;
         sb.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      operand_a = 16'($urandom);
      operand_b = 16'($urandom);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   // mode 1: MTHI/MTLO on the FIX->IDLE edge; mode 2: start + MTHI in busy cycle 5.
   task automatic wait_done(input string tag, input int mode, input bit chk_pulse);
      int   n;
      exp_t e;
      n = 0;
      while (done !== 1'b1 && n < 40) begin
         if (mode == 1 && n == 16) begin
            hi_we = 1'b1; lo_we = 1'b1; wr_data = 16'hABCD;
         end
         if (mode == 2 && n == 4) begin
            start = 1'b1; op = 2'b11; operand_a = 16'($urandom); operand_b = 16'h0003;
            hi_we = 1'b1; wr_data = 16'hABCD;
         end
         @(negedge clk);
         n++;
         start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      end
      chk({tag, "_latency"}, 32'(n), 32'd17);
      if (done === 1'b1) begin
         chk({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, {16'd0, Hi}, {16'd0, e.hi});
            chk({tag, "_lo"}, {16'd0, Lo}, {16'd0, e.lo});
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
         end else begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
         end
         if (chk_pulse) begin
            @(negedge clk);
            chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
         end
      end
   endtask

   initial begin
      rest = 1'b1; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0;
      hi_we = 1'b0; lo_we = 1'b0; wr_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
      chk("rst_hi", {16'd0, Hi}, 32'd0);
      chk("rst_lo", {16'd0, Lo}, 32'd0);
      rest = 1'b0;
      @(negedge clk);

      // MTHI+MTLO together in IDLE
      hi_we = 1'b1; lo_we = 1'b1; wr_data = 16'h5A5A;
      @(negedge clk);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("mt_both_hi", {16'd0, Hi}, 32'h5A5A);
      chk("mt_both_lo", {16'd0, Lo}, 32'h5A5A);

      // Reset during an operation
      issue(2'b01, 16'd3, 16'd5, '0, '0, 1'b0, 1'b0);
      repeat (7) @(negedge clk);
      rest = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_hi", {16'd0, Hi}, 32'd0);
      chk("midrst_lo", {16'd0, Lo}, 32'd0);
      rest = 1'b0;
      @(negedge clk);
      issue(2'b01, 16'd3, 16'd5, 16'd0, 16'd15, 1'b0, 1'b1);
      wait_done("multu_3x5", 0, 1'b1);

      issue(2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0, 1'b1);
      wait_done("multu_max", 0, 1'b1);
      issue(2'b00, 16'hFFFF, 16'h0002, 16'hFFFF, 16'hFFFE, 1'b0, 1'b1);
      wait_done("mult_neg", 0, 1'b1);
      issue(2'b10, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0, 1'b1);
      wait_done("div_m7_2", 1, 1'b1);
      issue(2'b11, 16'd100, 16'd7, 16'd2, 16'd14, 1'b0, 1'b1);
      wait_done("divu_100_7", 0, 1'b1);
      issue(2'b10, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b1);
      wait_done("div_wrap", 0, 1'b1);
      issue(2'b11, 16'd1234, 16'd0, 16'd1234, 16'hFFFF, 1'b1, 1'b1);
      wait_done("divu_by0", 0, 1'b1);

      // 0x0123 * -256 = 0xFFFEDD00; disturbance in busy cycle 5 must be ignored
      issue(2'b00, 16'h0123, 16'hFF00, 16'hFFFE, 16'hDD00, 1'b0, 1'b1);
      chk("dbz_cleared", {31'd0, div_by_zero}, 32'd0);
      wait_done("mult_disturbed", 2, 1'b1);

      lo_we = 1'b1; wr_data = 16'h1234;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo_lo", {16'd0, Lo}, 32'h1234);
      chk("mtlo_hi_kept", {16'd0, Hi}, 32'hFFFE);

      // Start in the done cycle
      issue(2'b01, 16'd7, 16'd6, 16'd0, 16'd42, 1'b0, 1'b1);
      wait_done("multu_7x6", 0, 1'b0);
      chk("b2b_done_cycle", {31'd0, done}, 32'd1);
      issue(2'b11, 16'd50, 16'd3, 16'd2, 16'd16, 1'b0, 1'b1);
      chk("b2b_done_dropped", {31'd0, done}, 32'd0);
      wait_done("divu_50_3", 0, 1'b1);

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
